// File: rtl/control_sequencer.sv
// control_sequencer
//   Moore step sequencer producing the datapath control strobes for
//   instruction fetch (with memory-ready wait) and register-format ALU
//   execution, with start/stop run control and a retired-instruction counter.
//
//   Optional feature macro: SEQ_ILLEGAL_TRAP_EN
//     defined   : an undefined opcode in T3 pulses `illegal` and parks in HALT
//                 until clear.
//     undefined : an undefined opcode is a NOP; `illegal` is tied to 0.
//
//   Ports
//     clock, clear         : rising-edge clock, synchronous active-high reset
//     start, stop          : run control (stop takes effect at an instruction boundary)
//     mem_rdy              : memory data valid during fetch (T1)
//     IR[31:0]             : instruction register fed back from the datapath
//     Rin[15:0], Rout[15:0]: one-hot general-register load / drive enables
//     PCout..Read          : datapath strobes
//     ADD..DIV             : ALU op selects
//     running              : high in T0..T6
//     illegal              : one-cycle pulse on an undefined opcode in T3
//     instr_count[CNT_W-1:0]: retired instructions (wraps)
//   All strobes are decoded combinationally from the state register and IR.
module control_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             mem_rdy,
    input  logic [31:0]      IR,
    output logic [15:0]      Rin,
    output logic [15:0]      Rout,
    output logic             PCout,
    output logic             PCin,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic             IncPC,
    output logic             Read,
    output logic             ADD,
    output logic             SUB,
    output logic             AND,
    output logic             OR,
    output logic             SHR,
    output logic             SHRA,
    output logic             SHL,
    output logic             ROR,
    output logic             ROL,
    output logic             NEG,
    output logic             NOT,
    output logic             MUL,
    output logic             DIV,
    output logic             running,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned NUM_OPS = 13;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7
`ifdef SEQ_ILLEGAL_TRAP_EN
        ,
        S_HALT = 4'd8
`endif
    } state_t;

    state_t             state, state_nx;
    logic               stop_pending, stop_pending_nx;
    logic               retire;
    logic [NUM_OPS-1:0] alu_op;

    // IR field decode
    logic [4:0]         op;
    logic [15:0]        ra_oh, rb_oh, rc_oh;
    logic [NUM_OPS-1:0] op_dec;
    logic               is_bin, is_un, is_md;
    logic               unused_ir;

    assign op        = IR[31:27];
    assign ra_oh     = 16'(1) << IR[26:23];
    assign rb_oh     = 16'(1) << IR[22:19];
    assign rc_oh     = 16'(1) << IR[18:15];
    assign op_dec    = NUM_OPS'(1) << op;
    assign is_bin    = (op <= 5'd8);
    assign is_un     = (op == 5'd9) || (op == 5'd10);
    assign is_md     = (op == 5'd11) || (op == 5'd12);
    assign unused_ir = ^IR[14:0];

    assign running = (state != S_IDLE)
`ifdef SEQ_ILLEGAL_TRAP_EN
                     && (state != S_HALT)
`endif
                     ;

    assign {DIV, MUL, NOT, NEG, ROL, ROR, SHL, SHRA, SHR, OR, AND, SUB, ADD} = alu_op;

    // State, stop flag and retire counter
    always_ff @(posedge clock) begin
        if (clear) begin
            state        <= S_IDLE;
            stop_pending <= 1'b0;
            instr_count  <= '0;
        end else begin
            state        <= state_nx;
            stop_pending <= stop_pending_nx;
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Next state and strobe decode
    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        Rin      = '0;
        Rout     = '0;
        PCout    = 1'b0;
        PCin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        alu_op   = '0;
        illegal  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_nx = S_T0;
                end
            end
            S_T0: begin
                PCout    = 1'b1;
                MARin    = 1'b1;
                IncPC    = 1'b1;
                Zin      = 1'b1;
                state_nx = S_T1;
            end
            S_T1: begin
                // Re-loading PC from unchanged Z while waiting is harmless
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_rdy) begin
                    state_nx = S_T2;
                end
            end
            S_T2: begin
                MDRout   = 1'b1;
                IRin     = 1'b1;
                state_nx = S_T3;
            end
            S_T3: begin
                if (is_bin) begin
                    Rout     = rb_oh;
                    Yin      = 1'b1;
                    state_nx = S_T4;
                end else if (is_un) begin
                    Rout     = rb_oh;
                    alu_op   = op_dec;
                    Zin      = 1'b1;
                    state_nx = S_T4;
                end else if (is_md) begin
                    Rout     = ra_oh;
                    Yin      = 1'b1;
                    state_nx = S_T4;
                end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                    illegal  = 1'b1;
                    state_nx = S_HALT;
`else
                    // Undefined opcode behaves as a NOP
                    state_nx = (stop_pending || stop) ? S_IDLE : S_T0;
`endif
                end
            end
            S_T4: begin
                if (is_un) begin
                    Zlowout = 1'b1;
                    Rin     = ra_oh;
                    retire  = 1'b1;
                end else if (is_md) begin
                    Rout     = rb_oh;
                    alu_op   = op_dec;
                    Zin      = 1'b1;
                    state_nx = S_T5;
                end else begin
                    Rout     = rc_oh;
                    alu_op   = op_dec;
                    Zin      = 1'b1;
                    state_nx = S_T5;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_md) begin
                    LOin     = 1'b1;
                    state_nx = S_T6;
                end else begin
                    Rin    = ra_oh;
                    retire = 1'b1;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                retire   = 1'b1;
            end
`ifdef SEQ_ILLEGAL_TRAP_EN
            S_HALT: begin
                state_nx = S_HALT;
            end
`endif
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (retire) begin
            state_nx = (stop_pending || stop) ? S_IDLE : S_T0;
        end

        // Pending stop is consumed on entry to IDLE
        if (state_nx == S_IDLE) begin
            stop_pending_nx = 1'b0;
        end else if (running && stop) begin
            stop_pending_nx = 1'b1;
        end else begin
            stop_pending_nx = stop_pending;
        end
    end

endmodule
